// File: rtl/mem_port_arbiter_if.sv
// PicoRV32-style memory port bundle.
// "master" is the side that issues requests (valid/instr/addr/wdata/wstrb)
// and receives completions (ready/rdata). "slave" is the serving side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_valid;
    logic                    mem_instr;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single PicoRV32-style memory port.
// One requester is granted at a time; its command is latched and held on the
// downstream port until the bridge pulses ready, and the completion is routed
// back to the granted requester only.
// Optional statistics counters are enabled with MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic aclk,
    input  logic areset,
    mem_port_arbiter_if.slave  s0,
    mem_port_arbiter_if.slave  s1,
    mem_port_arbiter_if.master m,
    output logic busy,
    output logic grant_id
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_grant0,
    output logic [31:0] stat_grant1,
    output logic [31:0] stat_wait0,
    output logic [31:0] stat_wait1
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [1:0] req_valid;
    logic       any_valid;
    logic       winner;
    logic       grant_id_reg;
    logic       last_grant_reg;

    logic                    instr_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH/8-1:0] wstrb_reg;

    logic [1:0]                 port_ready;
    logic [1:0][DATA_WIDTH-1:0] port_rdata;

    assign req_valid = {s1.mem_valid, s0.mem_valid};
    assign any_valid = |req_valid;

    // Winner selection: lone requester wins; on a tie either port 0 wins
    // (fixed priority) or the port that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_reg;
        end else if (req_valid[1]) begin
            winner = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: grant whenever anyone asks, release on downstream ready.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid)   state_next = BUSY;
            BUSY:    if (m.mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: valid is gated by ready so the bridge never re-samples a
    // request in the cycle it completes.
    always_comb begin
        busy        = (state_reg == BUSY);
        m.mem_valid = (state_reg == BUSY) && !m.mem_ready;
    end

    // Command and grant registers, loaded only on the grant edge so later
    // changes on the requester inputs are ignored for the whole transaction.
    always_ff @(posedge aclk) begin
        if (areset) begin
            grant_id_reg   <= 1'b0;
            last_grant_reg <= 1'b1;
            instr_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
        end else if (state_reg == IDLE && any_valid) begin
            grant_id_reg   <= winner;
            last_grant_reg <= winner;
            instr_reg      <= winner ? s1.mem_instr : s0.mem_instr;
            addr_reg       <= winner ? s1.mem_addr  : s0.mem_addr;
            wdata_reg      <= winner ? s1.mem_wdata : s0.mem_wdata;
            wstrb_reg      <= winner ? s1.mem_wstrb : s0.mem_wstrb;
        end
    end

    assign m.mem_instr = instr_reg;
    assign m.mem_addr  = addr_reg;
    assign m.mem_wdata = wdata_reg;
    assign m.mem_wstrb = wstrb_reg;
    assign grant_id    = grant_id_reg;

    // Response routing: only the owner sees ready/rdata; stray ready in IDLE
    // is dropped because busy is low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign port_ready[gi] = busy && m.mem_ready && (grant_id_reg == 1'(gi));
            assign port_rdata[gi] = (grant_id_reg == 1'(gi)) ? m.mem_rdata : '0;
        end
    endgenerate

    assign s0.mem_ready = port_ready[0];
    assign s0.mem_rdata = port_rdata[0];
    assign s1.mem_ready = port_ready[1];
    assign s1.mem_rdata = port_rdata[1];

`ifdef MEM_PORT_ARBITER_STATS_EN
    // A port is "being served" when it owns the BUSY transaction or wins the
    // IDLE decision this cycle; any other cycle with valid high is a wait.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic        serving;
            logic [31:0] grant_cnt_reg;
            logic [31:0] wait_cnt_reg;

            assign serving = busy ? (grant_id_reg == 1'(gi))
                                  : (any_valid && (winner == 1'(gi)));

            // Per-port grant and wait counters, wrapping naturally.
            always_ff @(posedge aclk) begin
                if (areset) begin
                    grant_cnt_reg <= '0;
                    wait_cnt_reg  <= '0;
                end else begin
                    if (state_reg == IDLE && any_valid && winner == 1'(gi)) begin
                        grant_cnt_reg <= grant_cnt_reg + 32'd1;
                    end
                    if (req_valid[gi] && !serving) begin
                        wait_cnt_reg <= wait_cnt_reg + 32'd1;
                    end
                end
            end
        end
    endgenerate

    assign stat_grant0 = g_stats[0].grant_cnt_reg;
    assign stat_grant1 = g_stats[1].grant_cnt_reg;
    assign stat_wait0  = g_stats[0].wait_cnt_reg;
    assign stat_wait1  = g_stats[1].wait_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset and
// stray-ready sequences, a fixed-priority instance, and a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_if();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fs0_if();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fs1_if();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fm_if();

    logic busy, grant_id, f_busy, f_grant_id;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_wait0, stat_wait1;
    logic [31:0] f_stat_grant0, f_stat_grant1, f_stat_wait0, f_stat_wait1;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
        .aclk(aclk), .areset(areset),
        .s0(s0_if), .s1(s1_if), .m(m_if),
        .busy(busy), .grant_id(grant_id)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
        , .stat_wait0(stat_wait0), .stat_wait1(stat_wait1)
`endif
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
        .aclk(aclk), .areset(areset),
        .s0(fs0_if), .s1(fs1_if), .m(fm_if),
        .busy(f_busy), .grant_id(f_grant_id)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stat_grant0(f_stat_grant0), .stat_grant1(f_stat_grant1)
        , .stat_wait0(f_stat_wait0), .stat_wait1(f_stat_wait1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_port(input int p, input logic v, input logic instr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb);
        if (p == 0) begin
            s0_if.mem_valid = v; s0_if.mem_instr = instr; s0_if.mem_addr = addr;
            s0_if.mem_wdata = wdata; s0_if.mem_wstrb = wstrb;
        end else begin
            s1_if.mem_valid = v; s1_if.mem_instr = instr; s1_if.mem_addr = addr;
            s1_if.mem_wdata = wdata; s1_if.mem_wstrb = wstrb;
        end
    endtask

    typedef struct {
        bit        v0, v1;
        bit [31:0] a0, a1, d0, d1;
        bit [3:0]  st0, st1;
        bit        i0, i1;
        int        lat;
        bit [31:0] rdata;
        bit        mutate;
        bit        exp_gid;
    } vec_t;

    vec_t vecs [12];

    // One directed transaction: present requests, check grant and held
    // command for lat+1 BUSY cycles, complete, then drop the requests.
    task automatic run_vec(input int idx);
        vec_t v;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ei;
        v  = vecs[idx];
        ea = v.exp_gid ? v.a1  : v.a0;
        ed = v.exp_gid ? v.d1  : v.d0;
        es = v.exp_gid ? v.st1 : v.st0;
        ei = v.exp_gid ? v.i1  : v.i0;
        next_cycle();
        drive_port(0, v.v0, v.i0, v.a0, v.d0, v.st0);
        drive_port(1, v.v1, v.i1, v.a1, v.d1, v.st1);
        m_if.mem_ready = 1'b0;
        settle();
        chk("idle_busy", busy, 1'b0);
        chk("idle_mvalid", m_if.mem_valid, 1'b0);
        for (int k = 0; k <= v.lat; k++) begin
            next_cycle();
            if (v.mutate) begin
                drive_port(0, v.v0, ~v.i0, ~v.a0, ~v.d0, ~v.st0);
                drive_port(1, v.v1, ~v.i1, ~v.a1, ~v.d1, ~v.st1);
            end
            m_if.mem_ready = (k == v.lat);
            m_if.mem_rdata = (k == v.lat) ? v.rdata : 32'hDEAD_BEEF;
            settle();
            chk("busy", busy, 1'b1);
            chk("grant_id", grant_id, v.exp_gid);
            chk("m_addr", m_if.mem_addr, ea);
            chk("m_wdata", m_if.mem_wdata, ed);
            chk("m_wstrb", m_if.mem_wstrb, es);
            chk("m_instr", m_if.mem_instr, ei);
            chk("m_valid", m_if.mem_valid, (k != v.lat));
            chk("s0_ready", s0_if.mem_ready, (k == v.lat) && !v.exp_gid);
            chk("s1_ready", s1_if.mem_ready, (k == v.lat) && v.exp_gid);
            if (v.exp_gid) chk("s0_rdata_masked", s0_if.mem_rdata, 32'h0);
            else           chk("s1_rdata_masked", s1_if.mem_rdata, 32'h0);
            if (k == v.lat) begin
                if (v.exp_gid) chk("s1_rdata", s1_if.mem_rdata, v.rdata);
                else           chk("s0_rdata", s0_if.mem_rdata, v.rdata);
            end
        end
        next_cycle();
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m_if.mem_ready = 1'b0;
        settle();
        chk("post_busy", busy, 1'b0);
        chk("post_mvalid", m_if.mem_valid, 1'b0);
        $display("vec %0d: req={%0d,%0d} granted port %0d addr=0x%08h lat=%0d rdata=0x%08h",
                 idx, v.v0, v.v1, v.exp_gid, ea, v.lat, v.rdata);
    endtask

    // Randomized-run reference model state: per-port outstanding request.
    bit          pend [2];
    bit          pinstr [2];
    bit [31:0]   paddr [2];
    bit [31:0]   pwdata [2];
    bit [3:0]    pwstrb [2];
    bit          mdl_busy, mdl_owner, mdl_last;
    int          mdl_cd;
    int          txn_count;
    int          mdl_grants [2];
    int          mdl_waits [2];

    function automatic bit pick_winner(input bit p0, input bit p1, input bit last);
        if (p0 && p1) return !last;
        return p1;
    endfunction

    initial begin
        int g0;
        bit seen;
        areset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m_if.mem_ready = 1'b0;  m_if.mem_rdata = 32'h0;
        fs0_if.mem_valid = 1'b0; fs0_if.mem_instr = 1'b0; fs0_if.mem_addr = 32'h0;
        fs0_if.mem_wdata = 32'h0; fs0_if.mem_wstrb = 4'h0;
        fs1_if.mem_valid = 1'b0; fs1_if.mem_instr = 1'b0; fs1_if.mem_addr = 32'h0;
        fs1_if.mem_wdata = 32'h0; fs1_if.mem_wstrb = 4'h0;
        fm_if.mem_ready = 1'b0; fm_if.mem_rdata = 32'h0;

        //            v0 v1  a0            a1            d0            d1            st0   st1      i0 i1 lat rdata          mut gid
        vecs[0]  = '{1, 1, 32'h0000_1000, 32'h0000_2000, 32'h11,       32'h22,       4'h0, 4'h0,    0, 1, 1, 32'h0000_00A0, 0, 0};
        vecs[1]  = '{1, 1, 32'h0000_1004, 32'h0000_2004, 32'h33,       32'h44,       4'h0, 4'hF,    1, 0, 2, 32'h0000_00A1, 0, 1};
        vecs[2]  = '{1, 1, 32'h0000_1008, 32'h0000_2008, 32'h55,       32'h66,       4'h1, 4'h0,    0, 0, 0, 32'h0000_00A2, 0, 0};
        vecs[3]  = '{1, 1, 32'h0000_100C, 32'h0000_200C, 32'h77,       32'h88,       4'h0, 4'h8,    0, 1, 1, 32'h0000_00A3, 0, 1};
        vecs[4]  = '{1, 0, 32'h0000_0100, 32'h0000_0000, 32'h0,        32'h0,        4'h0, 4'h0,    0, 0, 3, 32'hCAFE_F00D, 0, 0};
        vecs[5]  = '{0, 1, 32'h0000_0000, 32'h2000_0004, 32'h0,        32'h1234_5678, 4'h0, 4'b0011, 0, 0, 3, 32'h0000_0000, 1, 1};
        vecs[6]  = '{1, 1, 32'h0000_3000, 32'h0000_4000, 32'hA5A5_0000, 32'h5A5A_0000, 4'h3, 4'hC,   1, 1, 2, 32'h1111_2222, 0, 0};
        vecs[7]  = '{0, 1, 32'h0000_3004, 32'h0000_4004, 32'h0,        32'hFFFF_0001, 4'h0, 4'hF,    0, 0, 0, 32'h3333_4444, 0, 1};
        vecs[8]  = '{1, 1, 32'h0000_3008, 32'h0000_4008, 32'h0,        32'h0,        4'h0, 4'h0,    1, 0, 1, 32'h5555_6666, 1, 0};
        vecs[9]  = '{1, 1, 32'h0000_300C, 32'h0000_400C, 32'h9,        32'hA,        4'h2, 4'h4,    0, 0, 2, 32'h7777_8888, 0, 1};
        vecs[10] = '{1, 1, 32'h0000_5000, 32'h0000_6000, 32'h1,        32'h2,        4'h0, 4'h0,    0, 0, 1, 32'h9999_AAAA, 0, 0};
        vecs[11] = '{0, 1, 32'h0000_5004, 32'h0000_6004, 32'h3,        32'h4,        4'h0, 4'h0,    0, 0, 1, 32'hBBBB_CCCC, 0, 1};

        next_cycle();
        next_cycle();
        areset = 1'b0;
        settle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_mvalid", m_if.mem_valid, 1'b0);
        chk("rst_maddr", m_if.mem_addr, 32'h0);
        chk("rst_mwdata", m_if.mem_wdata, 32'h0);
        chk("rst_mwstrb", m_if.mem_wstrb, 4'h0);
        chk("rst_minstr", m_if.mem_instr, 1'b0);
        chk("rst_s0_ready", s0_if.mem_ready, 1'b0);
        chk("rst_s1_ready", s1_if.mem_ready, 1'b0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Stray downstream ready while idle must not reach any requester.
        next_cycle();
        m_if.mem_ready = 1'b1;
        m_if.mem_rdata = 32'h0BAD_0BAD;
        settle();
        chk("stray_s0_ready", s0_if.mem_ready, 1'b0);
        chk("stray_s1_ready", s1_if.mem_ready, 1'b0);
        chk("stray_mvalid", m_if.mem_valid, 1'b0);
        next_cycle();
        m_if.mem_ready = 1'b0;
        settle();
        chk("stray_busy", busy, 1'b0);
        $display("stray ready in idle: ignored");

        // Reset in the middle of a port-0 transaction.
        next_cycle();
        drive_port(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        settle();
        next_cycle();
        settle();
        chk("midrst_pre_busy", busy, 1'b1);
        chk("midrst_pre_mvalid", m_if.mem_valid, 1'b1);
        areset = 1'b1;
        next_cycle();
        areset = 1'b0;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mvalid", m_if.mem_valid, 1'b0);
        chk("midrst_grant_id", grant_id, 1'b0);
        chk("midrst_maddr", m_if.mem_addr, 32'h0);
        $display("reset mid-transaction: arbiter returned to idle");
        run_vec(10);
        run_vec(11);

        // Fixed-priority instance: s0 always requesting starves s1.
        next_cycle();
        fs0_if.mem_valid = 1'b1; fs0_if.mem_addr = 32'h0000_0A00;
        fs1_if.mem_valid = 1'b1; fs1_if.mem_addr = 32'h0000_0B00;
        fm_if.mem_ready = 1'b1;  fm_if.mem_rdata = 32'h0F0F_0F0F;
        g0 = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            settle();
            chk("fp_s1_ready", fs1_if.mem_ready, 1'b0);
            chk("fp_mvalid_gated", fm_if.mem_valid, 1'b0);
            if (f_busy) begin
                chk("fp_grant_id", f_grant_id, 1'b0);
                chk("fp_maddr", fm_if.mem_addr, 32'h0000_0A00);
            end
            if (fs0_if.mem_ready) g0++;
        end
        chk("fp_s0_grants", (g0 >= 9), 1'b1);
        fs0_if.mem_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            next_cycle();
            settle();
            if (fs1_if.mem_ready) seen = 1'b1;
        end
        chk("fp_s1_served_after_s0_drops", seen, 1'b1);
        fs1_if.mem_valid = 1'b0;
        fm_if.mem_ready = 1'b0;
        $display("fixed priority: s0 served %0d times, s1 served after s0 dropped=%0d", g0, seen);

        // Randomized run against the transaction-level model.
        next_cycle();
        areset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m_if.mem_ready = 1'b0;
        next_cycle();
        areset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; mdl_grants[p] = 0; mdl_waits[p] = 0;
        end
        mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_cd = 0; txn_count = 0;

        for (int c = 0; c < 1500; c++) begin
            bit any, w;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1;
                    pinstr[p] = 1'($urandom_range(0, 1));
                    paddr[p]  = $urandom;
                    pwdata[p] = $urandom;
                    pwstrb[p] = 4'($urandom_range(0, 15));
                end
                drive_port(p, pend[p], pinstr[p], paddr[p], pwdata[p], pwstrb[p]);
            end
            m_if.mem_ready = mdl_busy ? (mdl_cd == 0) : ($urandom_range(0, 7) == 0);
            m_if.mem_rdata = $urandom;
            settle();

            chk("rnd_busy", busy, mdl_busy);
            chk("rnd_grant_id", grant_id, mdl_owner);
            chk("rnd_mvalid", m_if.mem_valid, mdl_busy && !m_if.mem_ready);
            if (mdl_busy) begin
                chk("rnd_maddr", m_if.mem_addr, paddr[mdl_owner]);
                chk("rnd_mwdata", m_if.mem_wdata, pwdata[mdl_owner]);
                chk("rnd_mwstrb", m_if.mem_wstrb, pwstrb[mdl_owner]);
                chk("rnd_minstr", m_if.mem_instr, pinstr[mdl_owner]);
            end
            chk("rnd_s0_ready", s0_if.mem_ready, mdl_busy && m_if.mem_ready && mdl_owner == 0);
            chk("rnd_s1_ready", s1_if.mem_ready, mdl_busy && m_if.mem_ready && mdl_owner == 1);
            chk("rnd_s0_rdata", s0_if.mem_rdata, (mdl_owner == 0) ? m_if.mem_rdata : 32'h0);
            chk("rnd_s1_rdata", s1_if.mem_rdata, (mdl_owner == 1) ? m_if.mem_rdata : 32'h0);
`ifdef MEM_PORT_ARBITER_STATS_EN
            chk("stat_grant0", stat_grant0, 32'(mdl_grants[0]));
            chk("stat_grant1", stat_grant1, 32'(mdl_grants[1]));
            chk("stat_wait0", stat_wait0, 32'(mdl_waits[0]));
            chk("stat_wait1", stat_wait1, 32'(mdl_waits[1]));
`endif

            any = pend[0] || pend[1];
            w   = pick_winner(pend[0], pend[1], mdl_last);
            for (int p = 0; p < 2; p++) begin
                bit served;
                served = mdl_busy ? (mdl_owner == 1'(p)) : (any && w == 1'(p));
                if (pend[p] && !served) mdl_waits[p]++;
            end
            if (mdl_busy) begin
                if (m_if.mem_ready) begin
                    txn_count++;
                    $display("rnd txn %0d: port %0d addr=0x%08h wstrb=0x%0h rdata=0x%08h",
                             txn_count, mdl_owner, paddr[mdl_owner], pwstrb[mdl_owner],
                             m_if.mem_rdata);
                    pend[mdl_owner] = 0;
                    mdl_busy = 0;
                end else begin
                    mdl_cd--;
                end
            end else if (any) begin
                mdl_busy  = 1;
                mdl_owner = w;
                mdl_last  = w;
                mdl_cd    = $urandom_range(0, 3);
                mdl_grants[w]++;
            end
            next_cycle();
        end
        chk("rnd_progress", (txn_count > 100), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter in front of the single PicoRV32-style memory port of the SoC's AXI4 master bridge.
- Example requesters: CPU and a DMA/debug loader.
- Grants one requester at a time, latches that requester's command, and forwards it downstream.
- Routes the downstream ready/rdata back to the granted requester only.
- Shapes downstream valid so the bridge never sees a stale request on the cycle it completes.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
FIXED_PRIORITY, 0, 0 = round-robin on contention; 1 = port 0 always wins

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
s0_mem_valid  in  1  port 0 request
s0_mem_instr  in  1  port 0 instruction-fetch flag
s0_mem_addr  in  ADDR_WIDTH  port 0 address
s0_mem_wdata  in  DATA_WIDTH  port 0 write data
s0_mem_wstrb  in  DATA_WIDTH/8  port 0 byte strobes; 0 = read
s0_mem_ready  out  1  port 0 completion pulse
s0_mem_rdata  out  DATA_WIDTH  port 0 read data
s1_mem_valid/instr/addr/wdata/wstrb/ready/rdata  same as port 0, for port 1
m_mem_valid  out  1  downstream request to bridge
m_mem_instr  out  1  downstream instr flag
m_mem_addr  out  ADDR_WIDTH  downstream address
m_mem_wdata  out  DATA_WIDTH  downstream write data
m_mem_wstrb  out  DATA_WIDTH/8  downstream strobes
m_mem_ready  in  1  downstream completion pulse
m_mem_rdata  in  DATA_WIDTH  downstream read data
busy  out  1  transaction in flight
grant_id  out  1  owner of current/last transaction

Behaviour:
- Clock and reset: one clock, aclk. Reset areset is synchronous, active-high.
- Reset values:
  - state=IDLE, busy=0, grant_id=0.
  - last_grant=1, so port 0 wins the first tie.
  - Latched m_mem_addr/wdata/wstrb/instr=0.
  - m_mem_valid=0, s0/s1_mem_ready=0.
- States: IDLE, BUSY.
- IDLE:
  - If any sN_mem_valid is high, select the winner:
    - Only one valid: that port wins.
    - Both valid, FIXED_PRIORITY=1: port 0 wins.
    - Both valid, FIXED_PRIORITY=0: the port != last_grant wins.
  - At the edge, latch the winner's addr/wdata/wstrb/instr into the m_mem_* registers; set grant_id=winner, last_grant=winner; go to BUSY.
  - No valid: stay in IDLE.
- BUSY:
  - m_mem_valid = busy && !m_mem_ready (combinational gate). Downstream valid drops in the same cycle the bridge pulses ready, so the bridge's IDLE re-sample sees 0.
  - On m_mem_ready=1: go to IDLE at the next edge.
- Response routing (combinational):
  - sN_mem_ready = busy && m_mem_ready && grant_id==N.
  - sN_mem_rdata = m_mem_rdata when grant_id==N, else 0.
- Latency:
  - Request seen in IDLE at cycle t gives m_mem_valid high from t+1.
  - Downstream ready at cycle r gives requester ready at r (0 added cycles).
  - Earliest next grant decision at r+1; next m_mem_valid at r+2.
- Busy and command registers:
  - busy=1 exactly while in BUSY.
  - m_mem_* command registers are stable for the whole BUSY period. Later changes on sN inputs are ignored.
- Requester drops valid mid-transaction: not legal for PicoRV32. The transaction still completes and the ready pulse is still issued.
- Contention: the losing requester is held (no ready) and wins the next IDLE decision under round-robin. Worst-case wait is one transaction.
- Stray m_mem_ready in IDLE: ignored; no sN_mem_ready is asserted.
- areset mid-transaction: returns to IDLE immediately and drops m_mem_valid. The bridge must be reset with the same reset.
- Writes and reads are handled identically; wstrb passes through unmodified.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: adds outputs stat_grant0, stat_grant1, stat_wait0, stat_wait1 (32 bits each). All clear on areset.
  - stat_grantN: +1 per grant to port N.
  - stat_waitN: +1 per cycle port N has valid high but is not the owner.
  - Counters wrap modulo 2^32.
- Not defined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Single read:
  - Stimulus: s0 valid, addr=0x0000_0100, wstrb=0; bridge returns ready 3 cycles after m_mem_valid with rdata=0xCAFE_F00D.
  - Required: s0_mem_ready pulses 1 cycle with that rdata; s1_mem_ready stays 0; m_mem_valid is low in the ready cycle.
- Simultaneous requests, FIXED_PRIORITY=0, from reset:
  - Stimulus: s0 and s1 both valid.
  - Required: port 0 served first, then port 1. Repeating the contention gives order 0,1,0,1.
- FIXED_PRIORITY=1:
  - Stimulus: s0 re-requests immediately after each ready, s1 continuously valid.
  - Required: s1 never granted while s0 keeps requesting.
- Write passthrough:
  - Stimulus: s1 write addr=0x2000_0004, wdata=0x1234_5678, wstrb=4'b0011; s1 changes its inputs while BUSY.
  - Required: m_mem_* hold the latched values for the whole BUSY period.
- Reset mid-transaction:
  - Stimulus: areset=1 for 1 cycle while BUSY.
  - Required: next cycle busy=0, m_mem_valid=0, grant_id=0; a subsequent s1 request is granted normally.
- With MEM_PORT_ARBITER_STATS_EN defined:
  - Stimulus: 5 contended transactions.
  - Required: stat_grant0 + stat_grant1 = 5; stat_waitN equals the counted stall cycles.
